// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the M68/Z80 work-RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M68  = 2'b01;
  localparam logic [1:0] OWN_Z80  = 2'b10;

  localparam logic [1:0] LANE_HI = 2'b10;
  localparam logic [1:0] LANE_LO = 2'b01;

  localparam int STARVE_W = 4;

  // Even Z80 byte addresses live in the upper half of the RAM word.
  function automatic logic [1:0] lane_be(input logic bsel);
    return bsel ? LANE_LO : LANE_HI;
  endfunction

endpackage

// File: rtl/z80_byte_lane.sv
// Z80 byte-lane mapping onto the 16-bit RAM word: write replication,
// byte-enable generation and read byte selection.
module z80_byte_lane
  import ram_arb_pkg::*;
(
  input  logic        i_bsel,
  input  logic [7:0]  i_wbyte,
  input  logic        i_rsel,
  input  logic [15:0] i_rword,
  output logic [15:0] o_wword,
  output logic [1:0]  o_be,
  output logic [7:0]  o_rbyte
);

  assign o_wword = {i_wbyte, i_wbyte};
  assign o_be    = lane_be(i_bsel);
  assign o_rbyte = i_rsel ? i_rword[7:0] : i_rword[15:8];

endmodule

// File: rtl/ram_bus_arbiter.sv
// Single-port work-RAM arbiter: fixed M68 priority with a Z80 starvation guard.
// Optional M68 bus lock is enabled with macro ARB_LOCK_EN.
module ram_bus_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m68_req,
  input  logic              m68_we,
  input  logic [1:0]        m68_be,
  input  logic [ADDR_W-1:0] m68_addr,
  input  logic [15:0]       m68_wdata,
`ifdef ARB_LOCK_EN
  input  logic              m68_lock,
`endif
  output logic              m68_ack,
  output logic [15:0]       m68_rdata,
  input  logic              z80_req,
  input  logic              z80_we,
  input  logic [ADDR_W:0]   z80_addr,
  input  logic [7:0]        z80_wdata,
  output logic              z80_ack,
  output logic [7:0]        z80_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [1:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic [1:0]        owner
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_t          r_state;
  logic [1:0]          r_owner;
  logic [STARVE_W-1:0] r_starve;
  logic                r_zsel;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [1:0]          r_ram_be;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [15:0]         r_ram_wdata;
  logic                r_m68_ack;
  logic                r_z80_ack;
  logic [15:0]         r_m68_rdata;
  logic [7:0]          r_z80_rdata;

  logic                w_grant_m68;
  logic                w_grant_z80;
  logic                w_lock_act;
  logic                w_lock_win;
  logic [15:0]         w_z_wword;
  logic [1:0]          w_z_be;
  logic [7:0]          w_z_rbyte;

  z80_byte_lane u_lane (
    .i_bsel  (z80_addr[0]),
    .i_wbyte (z80_wdata),
    .i_rsel  (r_zsel),
    .i_rword (ram_rdata),
    .o_wword (w_z_wword),
    .o_be    (w_z_be),
    .o_rbyte (w_z_rbyte)
  );

`ifdef ARB_LOCK_EN
  logic r_lock;

  assign w_lock_act = r_lock & m68_lock;
  assign w_lock_win = m68_lock;

  // Lock arms on an M68 win with m68_lock high; any IDLE cycle with it low releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_grant_m68 && m68_lock) begin
        r_lock <= 1'b1;
      end else if (!m68_lock) begin
        r_lock <= 1'b0;
      end
    end
  end
`else
  assign w_lock_act = 1'b0;
  assign w_lock_win = 1'b0;
`endif

  // Winner selection; only consumed while the FSM sits in IDLE.
  always_comb begin
    w_grant_m68 = 1'b0;
    w_grant_z80 = 1'b0;
    if (w_lock_act) begin
      w_grant_m68 = m68_req;
    end else if (m68_req && z80_req) begin
      if (r_starve >= LIMIT) begin
        w_grant_z80 = 1'b1;
      end else begin
        w_grant_m68 = 1'b1;
      end
    end else if (m68_req) begin
      w_grant_m68 = 1'b1;
    end else if (z80_req) begin
      w_grant_z80 = 1'b1;
    end else begin
      w_grant_m68 = 1'b0;
    end
  end

  // Access sequencer: latch winner, one RAM strobe, capture, one-cycle ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_NONE;
      r_starve    <= '0;
      r_zsel      <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_be    <= 2'b00;
      r_ram_addr  <= '0;
      r_ram_wdata <= 16'h0000;
      r_m68_ack   <= 1'b0;
      r_z80_ack   <= 1'b0;
      r_m68_rdata <= 16'h0000;
      r_z80_rdata <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_m68) begin
            r_state     <= ACCESS;
            r_owner     <= OWN_M68;
            r_ram_en    <= 1'b1;
            r_ram_we    <= m68_we;
            r_ram_be    <= m68_be;
            r_ram_addr  <= m68_addr;
            r_ram_wdata <= m68_wdata;
            if (z80_req && !w_lock_win && (r_starve < LIMIT)) begin
              r_starve <= r_starve + 1'b1;
            end
          end else if (w_grant_z80) begin
            r_state     <= ACCESS;
            r_owner     <= OWN_Z80;
            r_ram_en    <= 1'b1;
            r_ram_we    <= z80_we;
            r_ram_be    <= w_z_be;
            r_ram_addr  <= z80_addr[ADDR_W:1];
            r_ram_wdata <= w_z_wword;
            r_zsel      <= z80_addr[0];
            r_starve    <= '0;
          end else begin
            r_owner <= OWN_NONE;
          end
        end
        ACCESS: begin
          r_ram_en <= 1'b0;
          r_state  <= CAPTURE;
        end
        CAPTURE: begin
          if (r_owner == OWN_M68) begin
            r_m68_ack <= 1'b1;
            if (!r_ram_we) begin
              r_m68_rdata <= ram_rdata;
            end
          end else begin
            r_z80_ack <= 1'b1;
            if (!r_ram_we) begin
              r_z80_rdata <= w_z_rbyte;
            end
          end
          r_state <= ACK;
        end
        ACK: begin
          r_m68_ack <= 1'b0;
          r_z80_ack <= 1'b0;
          r_owner   <= OWN_NONE;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m68_ack   = r_m68_ack;
  assign m68_rdata = r_m68_rdata;
  assign z80_ack   = r_z80_ack;
  assign z80_rdata = r_z80_rdata;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_be    = r_ram_be;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign owner     = r_owner;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed vector table, reset and
// contention sequences, then randomized traffic against a byte-array reference.
module tb_ram_bus_arbiter;

  localparam int AW    = 12;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m68_req = 1'b0, m68_we = 1'b0;
  logic [1:0]    m68_be = 2'b00;
  logic [AW-1:0] m68_addr = '0;
  logic [15:0]   m68_wdata = 16'h0000;
  logic          m68_ack;
  logic [15:0]   m68_rdata;
  logic          z80_req = 1'b0, z80_we = 1'b0;
  logic [AW:0]   z80_addr = '0;
  logic [7:0]    z80_wdata = 8'h00;
  logic          z80_ack;
  logic [7:0]    z80_rdata;
  logic          ram_en, ram_we;
  logic [1:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;
  logic [1:0]    owner;
`ifdef ARB_LOCK_EN
  logic          m68_lock = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ram_bus_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m68_req(m68_req), .m68_we(m68_we), .m68_be(m68_be), .m68_addr(m68_addr),
    .m68_wdata(m68_wdata),
`ifdef ARB_LOCK_EN
    .m68_lock(m68_lock),
`endif
    .m68_ack(m68_ack), .m68_rdata(m68_rdata),
    .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr), .z80_wdata(z80_wdata),
    .z80_ack(z80_ack), .z80_rdata(z80_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int a);
    if (a == 16'h010) return 16'hBEEF;
    if (a == 16'h011) return 16'hA5C3;
    return {a[7:0], ~a[7:0]};
  endfunction

  // RAM macro model: one-cycle read latency, byte-masked writes, reloaded on reset.
  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
      ram_rdata <= 16'h0000;
    end else if (ram_en) begin
      if (ram_we && ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
      if (ram_we && ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {m68_ack, z80_ack, ram_en, ram_we, ram_be, owner}, 32'h0);
    check({tag, "_addr"}, {20'h0, ram_addr}, 32'h0);
    check({tag, "_data"}, {ram_wdata, m68_rdata}, 32'h0);
    check({tag, "_zrd"}, {24'h0, z80_rdata}, 32'h0);
  endtask

  typedef struct {
    bit          z80;
    bit          we;
    logic [1:0]  be;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic [11:0] exp_addr;
    logic [1:0]  exp_be;
    logic [15:0] exp_wd;
  } vec_t;

  task automatic run_txn(input vec_t v);
    logic [15:0] got;
    @(posedge clk);
    @(negedge clk);
    if (v.z80) begin
      z80_req = 1'b1; z80_we = v.we; z80_addr = v.addr; z80_wdata = v.wdata[7:0];
    end else begin
      m68_req = 1'b1; m68_we = v.we; m68_be = v.be; m68_addr = v.addr[11:0];
      m68_wdata = v.wdata;
    end
    @(posedge clk); #1;
    check("en_n1", {31'h0, ram_en}, 32'h1);
    check("owner_n1", {30'h0, owner}, v.z80 ? 32'h2 : 32'h1);
    check("ram_we", {31'h0, ram_we}, {31'h0, v.we});
    check("ram_addr", {20'h0, ram_addr}, {20'h0, v.exp_addr});
    if (v.we) begin
      check("ram_be", {30'h0, ram_be}, {30'h0, v.exp_be});
      check("ram_wdata", {16'h0, ram_wdata}, {16'h0, v.exp_wd});
    end
    @(posedge clk); #1;
    check("en_n2", {31'h0, ram_en}, 32'h0);
    check("ack_n2", {30'h0, m68_ack, z80_ack}, 32'h0);
    check("owner_n2", {30'h0, owner}, v.z80 ? 32'h2 : 32'h1);
    @(posedge clk); #1;
    check("ack_n3", {30'h0, m68_ack, z80_ack}, v.z80 ? 32'h1 : 32'h2);
    check("owner_n3", {30'h0, owner}, v.z80 ? 32'h2 : 32'h1);
    got = v.z80 ? {8'h00, z80_rdata} : m68_rdata;
    if (!v.we) check("rdata_n3", {16'h0, got}, {16'h0, v.exp_rd});
    m68_req = 1'b0;
    z80_req = 1'b0;
    @(posedge clk); #1;
    check("ack_n4", {30'h0, m68_ack, z80_ack}, 32'h0);
    check("owner_n4", {30'h0, owner}, 32'h0);
    got = v.z80 ? {8'h00, z80_rdata} : m68_rdata;
    if (!v.we) check("rdata_hold", {16'h0, got}, {16'h0, v.exp_rd});
  endtask

  vec_t        vecs [12];
  int          streak, grants, cyc, next_free, gcyc, win, m_last_ack, z_last_ack, a;
  logic        exp_we, exp_z;
  logic [15:0] exp_rd;
  logic [7:0]  sb [0:15];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 2'b11, 13'h010, 16'h0000, 16'hBEEF, 12'h010, 2'b11, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 2'b00, 13'h021, 16'h005A, 16'h0000, 12'h010, 2'b01, 16'h5A5A};
    vecs[2]  = '{1'b0, 1'b0, 2'b11, 13'h010, 16'h0000, 16'hBE5A, 12'h010, 2'b11, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 2'b11, 13'h010, 16'h1234, 16'h0000, 12'h010, 2'b11, 16'h1234};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 13'h020, 16'h0000, 16'h0012, 12'h010, 2'b10, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 13'h021, 16'h0000, 16'h0034, 12'h010, 2'b01, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 13'h011, 16'hFFFF, 16'h0000, 12'h011, 2'b00, 16'hFFFF};
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 13'h011, 16'h0000, 16'hA5C3, 12'h011, 2'b11, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 2'b10, 13'h011, 16'h7700, 16'h0000, 12'h011, 2'b10, 16'h7700};
    vecs[9]  = '{1'b0, 1'b0, 2'b11, 13'h011, 16'h0000, 16'h77C3, 12'h011, 2'b11, 16'h0000};
    vecs[10] = '{1'b1, 1'b1, 2'b00, 13'h022, 16'h00C4, 16'h0000, 12'h011, 2'b10, 16'hC4C4};
    vecs[11] = '{1'b0, 1'b0, 2'b11, 13'h011, 16'h0000, 16'hC4C3, 12'h011, 2'b11, 16'h0000};

    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_hold");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 12; i++) run_txn(vecs[i]);

    // Reset while the RAM strobe is active abandons the access.
    @(posedge clk);
    @(negedge clk);
    m68_req = 1'b1; m68_we = 1'b0; m68_be = 2'b11; m68_addr = 12'h010;
    @(posedge clk); #1;
    check("mid_en", {31'h0, ram_en}, 32'h1);
    rst = 1'b1;
    #1 check_all_zero("mid_reset");
    m68_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_ack", {30'h0, m68_ack, z80_ack}, 32'h0);
    end
    run_txn(vecs[0]);

    // Continuous contention: grant order follows the starvation guard.
    streak = 0;
    grants = 0;
    @(negedge clk);
    m68_req = 1'b1; m68_we = 1'b0; m68_addr = 12'h011;
    z80_req = 1'b1; z80_we = 1'b0; z80_addr = 13'h021;
    for (int c = 0; c < 200 && grants < 15; c++) begin
      @(negedge clk);
      check("dual_ack", {31'h0, m68_ack & z80_ack}, 32'h0);
      if (m68_ack || z80_ack) begin
        exp_z = (streak >= LIMIT);
        check("grant_order", {31'h0, z80_ack}, {31'h0, exp_z});
        if (exp_z) streak = 0;
        else if (streak < LIMIT) streak++;
        grants++;
      end
    end
    check("contention_grants", grants, 15);
    m68_req = 1'b0;
    z80_req = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized traffic against a byte-addressed reference memory.
    for (int w = 0; w < 8; w++) {sb[2*w], sb[2*w+1]} = init_word(w);
    win = 0; gcyc = -100; next_free = 0; m_last_ack = -10; z_last_ack = -10;
    exp_we = 1'b0; exp_rd = 16'h0000;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check("r_m68_ack", {31'h0, m68_ack}, {31'h0, (win == 1 && cyc == gcyc + 3)});
      check("r_z80_ack", {31'h0, z80_ack}, {31'h0, (win == 2 && cyc == gcyc + 3)});
      check("r_ram_en", {31'h0, ram_en}, {31'h0, (win != 0 && cyc == gcyc + 1)});
      check("r_owner", {30'h0, owner},
            (win != 0 && cyc >= gcyc + 1 && cyc <= gcyc + 3) ? win : 0);
      if (win == 1 && cyc == gcyc + 3) begin
        if (!exp_we) check("r_m68_rdata", {16'h0, m68_rdata}, {16'h0, exp_rd});
        m68_req = 1'b0;
        m_last_ack = cyc;
      end
      if (win == 2 && cyc == gcyc + 3) begin
        if (!exp_we) check("r_z80_rdata", {24'h0, z80_rdata}, {16'h0, exp_rd});
        z80_req = 1'b0;
        z_last_ack = cyc;
      end
      if (!m68_req && cyc >= m_last_ack + 2 && cyc < 2990 && $urandom_range(0, 3) != 0) begin
        m68_req = 1'b1; m68_we = 1'($urandom_range(0, 1)); m68_be = 2'($urandom_range(0, 3));
        m68_addr = 12'($urandom_range(0, 7)); m68_wdata = 16'($urandom);
      end
      if (!z80_req && cyc >= z_last_ack + 2 && cyc < 2990 && $urandom_range(0, 1) != 0) begin
        z80_req = 1'b1; z80_we = 1'($urandom_range(0, 1));
        z80_addr = 13'($urandom_range(0, 15)); z80_wdata = 8'($urandom);
      end
      if (cyc >= next_free && (m68_req || z80_req)) begin
        if (m68_req && (!z80_req || streak < LIMIT)) begin
          win = 1;
          if (z80_req && streak < LIMIT) streak++;
          a = int'(m68_addr);
          exp_we = m68_we;
          if (m68_we) begin
            if (m68_be[1]) sb[2*a] = m68_wdata[15:8];
            if (m68_be[0]) sb[2*a+1] = m68_wdata[7:0];
          end else begin
            exp_rd = {sb[2*a], sb[2*a+1]};
          end
        end else begin
          win = 2;
          streak = 0;
          a = int'(z80_addr);
          exp_we = z80_we;
          if (z80_we) sb[a] = z80_wdata;
          else exp_rd = {8'h00, sb[a]};
        end
        gcyc = cyc;
        next_free = cyc + 4;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares one single-port synchronous work RAM between the M68 requester (16-bit word) and the Z80 requester (8-bit byte).
- Fixed M68 priority with a Z80 starvation guard; req/ack handshake per requester.
- Sits between CPU bus adapters and the RAM macro; sequences en/we/addr/lane strobes and returns read data per requester.

Parameters:
ADDR_W, 12, RAM word-address width
STARVE_LIMIT, 4, consecutive M68 wins while z80_req is pending before Z80 is forced to win (1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
m68_req  in  1  M68 access request; held high until ack
m68_we  in  1  1=write, 0=read
m68_be  in  2  byte enables, [1]=bits 15:8, [0]=bits 7:0
m68_addr  in  ADDR_W  word address
m68_wdata  in  16  write data
m68_ack  out  1  one-cycle completion pulse
m68_rdata  out  16  read data, valid while m68_ack=1
z80_req  in  1  Z80 access request; held high until ack
z80_we  in  1  1=write
z80_addr  in  ADDR_W+1  byte address; bit0=0 selects upper byte (15:8), bit0=1 selects lower byte
z80_wdata  in  8  write byte
z80_ack  out  1  one-cycle completion pulse
z80_rdata  out  8  read byte, valid while z80_ack=1
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_be  out  2  RAM byte enables
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  16  RAM write data
ram_rdata  in  16  RAM read data; valid the cycle after ram_en
owner  out  2  current owner: 00 none, 01 M68, 10 Z80

Behaviour:
- Reset: all outputs 0; state IDLE; starve_cnt=0. Reset mid-transaction abandons the access with no ack; requesters must re-request.
- All outputs are registered.
- FSM: IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE.
- IDLE:
  - Sample requests and pick a winner.
  - Latch the winner's we/be/addr/wdata; input changes after this point are ignored.
  - Set owner. No request means stay in IDLE with owner=00.
- ACCESS: ram_en=1 for exactly one cycle with latched ram_we/ram_be/ram_addr/ram_wdata.
- CAPTURE: ram_en=0. On a read, register ram_rdata into the winner's rdata. Z80 lane: addr bit0=0 takes 15:8, bit0=1 takes 7:0.
- ACK:
  - Winner's ack=1 for one cycle; rdata stays valid and holds afterwards.
  - owner returns to 00 entering IDLE.
  - Writes also go through CAPTURE, so all accesses take the same time.
- Latency: req sampled in IDLE at cycle N -> ram_en at N+1 -> ack at N+3. IDLE re-arbitrates at N+4.
- Requester rule: drop req by the end of the cycle after ack. A new request may assert from N+5.
- Z80 write: ram_wdata={z80_wdata,z80_wdata}; ram_be=2'b10 if bit0=0, else 2'b01. ram_addr=z80_addr[ADDR_W:1].
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: M68 wins unless starve_cnt>=STARVE_LIMIT, then Z80 wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) on each M68 win while z80_req=1. It clears on every Z80 win.
- m68_be=00 with m68_req=1: still performs a full handshake; ram_en asserts with ram_be=00, no RAM change.
- Both acks are never high in the same cycle.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - Extra input m68_lock (1 bit).
  - If m68_lock=1 when M68 wins, Z80 is never granted while m68_lock remains 1, regardless of starve_cnt.
  - starve_cnt is frozen during the lock.
  - The lock releases the first IDLE cycle in which m68_lock=0.
- Undefined: port absent; arbitration exactly as above.

Decomposition:
- Package ram_arb_pkg:
  - state enum (IDLE, ACCESS, CAPTURE, ACK);
  - owner encodings OWN_NONE/OWN_M68/OWN_Z80;
  - lane constants LANE_HI=2'b10, LANE_LO=2'b01.
- One sub-module z80_byte_lane: holds the Z80 byte-lane logic (write replication, be generation, read byte select).

Test Plan:
- M68 read, addr 0x010, RAM word 0xBEEF, no Z80 -> ram_en at N+1; m68_ack at N+3 with m68_rdata=0xBEEF; owner=01 during N+1..N+3.
- Z80 write, addr 0x021, data 0x5A -> ram_addr=0x010, ram_be=01, ram_wdata=0x5A5A; z80_ack at N+3; a later M68 read of 0x010 returns the low byte 0x5A.
- Z80 read, byte addr 0x020, RAM word 0x1234 -> z80_rdata=0x12; byte addr 0x021 -> z80_rdata=0x34.
- Both requesting continuously, STARVE_LIMIT=4 -> grant order M68,M68,M68,M68,Z80, repeating; never two acks in the same cycle.
- rst asserted during ACCESS -> all outputs 0 in the same cycle, no ack; after release a fresh request completes normally.
- ARB_LOCK_EN defined, m68_lock=1 for 8 M68 transactions with z80_req high -> no Z80 grant until lock drops; Z80 wins the next contended arbitration only if starve_cnt (frozen during the lock) is at STARVE_LIMIT.
